// File: rtl/stream_demux_pkg.sv
// Shared types and sizes for the 1:4 stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demultiplexer with a one-entry output buffer.
// Optional per-channel transfer counters: define STREAM_DEMUX_XFER_CNT_EN.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_data,
  input  logic [1:0]   up_sel,
  output logic         d0_vld,
  output logic         d1_vld,
  output logic         d2_vld,
  output logic         d3_vld,
  input  logic         d0_rdy,
  input  logic         d1_rdy,
  input  logic         d2_rdy,
  input  logic         d3_rdy,
  output logic [W-1:0] d0,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic [W-1:0] d3,
  output logic [31:0]  xfer_cnt
);

  state_t         state_q, state_d;
  logic [W-1:0]   buf_data_q, buf_data_d;
  sel_t           buf_sel_q, buf_sel_d;
  logic           buf_vld;
  logic [N_CH-1:0] rdy_v;
  logic           down_fire;
  logic           up_fire;

  // Handshake terms; the only ready-to-output combinational path is into up_rdy.
  assign buf_vld   = (state_q == FULL);
  assign rdy_v     = {d3_rdy, d2_rdy, d1_rdy, d0_rdy};
  assign down_fire = buf_vld && rdy_v[buf_sel_q];
  assign up_rdy    = !buf_vld || down_fire;
  assign up_fire   = up_vld && up_rdy;

  // State register: buffer occupancy, word and destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      buf_data_q <= '0;
      buf_sel_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_sel_q  <= buf_sel_d;
    end
  end

  // Next-state: load on up_fire, drain on down_fire, otherwise hold.
  always_comb begin
    state_d    = state_q;
    buf_data_d = buf_data_q;
    buf_sel_d  = buf_sel_q;
    case (state_q)
      EMPTY: begin
        if (up_fire) begin
          state_d    = FULL;
          buf_data_d = up_data;
          buf_sel_d  = sel_t'(up_sel);
        end
      end
      FULL: begin
        if (down_fire) begin
          if (up_fire) begin
            buf_data_d = up_data;
            buf_sel_d  = sel_t'(up_sel);
          end else begin
            state_d    = EMPTY;
            buf_data_d = '0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output decode: only the selected channel shows valid and data, others read 0.
  always_comb begin
    d0_vld = 1'b0;
    d1_vld = 1'b0;
    d2_vld = 1'b0;
    d3_vld = 1'b0;
    d0     = '0;
    d1     = '0;
    d2     = '0;
    d3     = '0;
    if (buf_vld) begin
      case (buf_sel_q)
        2'd0: begin d0_vld = 1'b1; d0 = buf_data_q; end
        2'd1: begin d1_vld = 1'b1; d1 = buf_data_q; end
        2'd2: begin d2_vld = 1'b1; d2 = buf_data_q; end
        default: begin d3_vld = 1'b1; d3 = buf_data_q; end
      endcase
    end
  end

`ifdef STREAM_DEMUX_XFER_CNT_EN
  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    // Wrapping count of words delivered on channel g.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (down_fire && (buf_sel_q == sel_t'(g))) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign xfer_cnt[CNT_W*g +: CNT_W] = cnt_q;
  end
`else
  assign xfer_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Scoreboard bench for stream_demux_1_4; honours STREAM_DEMUX_XFER_CNT_EN.
module tb_stream_demux_1_4;

  localparam int unsigned W = 4;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         up_vld;
  logic         up_rdy;
  logic [W-1:0] up_data;
  logic [1:0]   up_sel;
  logic         d0_vld, d1_vld, d2_vld, d3_vld;
  logic         d0_rdy, d1_rdy, d2_rdy, d3_rdy;
  logic [W-1:0] d0, d1, d2, d3;
  logic [31:0]  xfer_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;
  exp_t sb[$];

  logic [3:0]   vld_v;
  logic [3:0]   rdy_v;
  logic [W-1:0] dat_v [4];

  assign vld_v = {d3_vld, d2_vld, d1_vld, d0_vld};
  assign rdy_v = {d3_rdy, d2_rdy, d1_rdy, d0_rdy};
  assign dat_v[0] = d0;
  assign dat_v[1] = d1;
  assign dat_v[2] = d2;
  assign dat_v[3] = d3;

  stream_demux_1_4 #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .up_vld(up_vld), .up_rdy(up_rdy), .up_data(up_data), .up_sel(up_sel),
    .d0_vld(d0_vld), .d1_vld(d1_vld), .d2_vld(d2_vld), .d3_vld(d3_vld),
    .d0_rdy(d0_rdy), .d1_rdy(d1_rdy), .d2_rdy(d2_rdy), .d3_rdy(d3_rdy),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: pop on each downstream transfer, push on each upstream transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (vld_v[n] && rdy_v[n]) begin
          cmp_cnt++;
          if (sb.size() == 0) begin
            err_cnt++;
            $display("FAIL sb_pop: ch%0d delivered %h, expected no word pending", n, dat_v[n]);
          end else begin
            e = sb.pop_front();
            if (e.sel !== 2'(n) || e.data !== dat_v[n]) begin
              err_cnt++;
              $display("FAIL sb_pop: got ch%0d data %h, expected ch%0d data %h", n, dat_v[n], e.sel, e.data);
            end
          end
        end
      end
      if (up_vld && up_rdy) sb.push_back('{sel: up_sel, data: up_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic [3:0] r);
    {d3_rdy, d2_rdy, d1_rdy, d0_rdy} = r;
  endtask

  task automatic test_reset();
    rst = 1'b1; up_vld = 1'b0; up_data = '0; up_sel = '0;
    set_rdy(4'b0000);
    #12;
    cmp_cnt++;
    if ({d3_vld, d2_vld, d1_vld, d0_vld} !== 4'b0 || {d3, d2, d1, d0} !== '0 || xfer_cnt !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_vals: vld=%b data=%h cnt=%h, expected all 0", vld_v, {d3, d2, d1, d0}, xfer_cnt);
    end
    tick(); rst = 1'b0;
    cmp_cnt++;
    if (up_rdy !== 1'b1) begin err_cnt++; $display("FAIL reset_uprdy: got %b, expected 1", up_rdy); end
    up_vld = 1'b1; up_sel = 2'd2; up_data = 4'hA;
    tick(); up_vld = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (d2_vld !== 1'b1 || d2 !== 4'hA) begin
      err_cnt++; $display("FAIL reset_load: d2_vld=%b d2=%h, expected 1 A", d2_vld, d2);
    end
    #2 rst = 1'b1;
    #1;
    cmp_cnt++;
    if (d2_vld !== 1'b0 || {d3, d2, d1, d0} !== '0) begin
      err_cnt++; $display("FAIL reset_async: d2_vld=%b data=%h, expected 0 0", d2_vld, {d3, d2, d1, d0});
    end
    sb.delete();
    tick(); rst = 1'b0;
    cmp_cnt++;
    if (up_rdy !== 1'b1 || d2_vld !== 1'b0) begin
      err_cnt++; $display("FAIL reset_release: up_rdy=%b d2_vld=%b, expected 1 0", up_rdy, d2_vld);
    end
  endtask

  task automatic test_single();
    set_rdy(4'b1111);
    tick(); up_vld = 1'b1; up_sel = 2'd1; up_data = 4'h5;
    tick(); up_vld = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (vld_v !== 4'b0010 || d1 !== 4'h5 || d0 !== '0 || d2 !== '0 || d3 !== '0) begin
      err_cnt++;
      $display("FAIL single_out: vld=%b data=%h, expected 0010 0050", vld_v, {d3, d2, d1, d0});
    end
    tick();
    @(negedge clk);
    cmp_cnt++;
    if (vld_v !== 4'b0000 || {d3, d2, d1, d0} !== '0) begin
      err_cnt++; $display("FAIL single_drain: vld=%b data=%h, expected 0000 0", vld_v, {d3, d2, d1, d0});
    end
  endtask

  task automatic test_stall();
    set_rdy(4'b0111);
    tick(); up_vld = 1'b1; up_sel = 2'd3; up_data = 4'hC;
    tick(); up_sel = 2'd0; up_data = 4'h7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cmp_cnt++;
      if (d3_vld !== 1'b1 || d3 !== 4'hC || up_rdy !== 1'b0 || sb.size() != 1) begin
        err_cnt++;
        $display("FAIL stall_hold c%0d: d3_vld=%b d3=%h up_rdy=%b pending=%0d, expected 1 C 0 1",
                 c, d3_vld, d3, up_rdy, sb.size());
      end
      tick();
    end
    d3_rdy = 1'b1;
    #1;
    cmp_cnt++;
    if (up_rdy !== 1'b1) begin err_cnt++; $display("FAIL stall_release: up_rdy=%b, expected 1", up_rdy); end
    tick(); up_vld = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (d0_vld !== 1'b1 || d0 !== 4'h7 || d3_vld !== 1'b0) begin
      err_cnt++; $display("FAIL stall_next: d0_vld=%b d0=%h d3_vld=%b, expected 1 7 0", d0_vld, d0, d3_vld);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_rdy(4'b1111);
    for (int i = 0; i <= 5; i++) begin
      tick();
      if (i < 5) begin
        up_vld = 1'b1; up_sel = 2'(i % 4); up_data = W'(i + 1);
      end else begin
        up_vld = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        cmp_cnt++;
        if (vld_v !== 4'(1 << ((i - 1) % 4)) || dat_v[(i - 1) % 4] !== W'(i) || (i < 5 && up_rdy !== 1'b1)) begin
          err_cnt++;
          $display("FAIL b2b word%0d: vld=%b data=%h up_rdy=%b, expected ch%0d data %h",
                   i - 1, vld_v, {d3, d2, d1, d0}, up_rdy, (i - 1) % 4, i);
        end
      end
    end
    tick();
  endtask

  task automatic test_wrong_ready();
    set_rdy(4'b1110);
    tick(); up_vld = 1'b1; up_sel = 2'd0; up_data = 4'h9;
    tick(); up_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmp_cnt++;
      if (d0_vld !== 1'b1 || d0 !== 4'h9 || up_rdy !== 1'b0) begin
        err_cnt++;
        $display("FAIL wrong_rdy c%0d: d0_vld=%b d0=%h up_rdy=%b, expected 1 9 0", c, d0_vld, d0, up_rdy);
      end
      tick();
    end
    d0_rdy = 1'b1;
    tick();
    @(negedge clk);
    cmp_cnt++;
    if (d0_vld !== 1'b0) begin err_cnt++; $display("FAIL wrong_rdy_drain: d0_vld=%b, expected 0", d0_vld); end
  endtask

  task automatic test_counter();
    logic [31:0] exp_cnt;
`ifdef STREAM_DEMUX_XFER_CNT_EN
    exp_cnt = 32'h0001_0000;
`else
    exp_cnt = 32'h0;
`endif
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    set_rdy(4'b1111);
    up_vld = 1'b1; up_sel = 2'd2;
    for (int i = 0; i < 257; i++) begin
      up_data = W'(i);
      tick();
    end
    up_vld = 1'b0;
    tick(); tick();
    cmp_cnt++;
    if (xfer_cnt !== exp_cnt) begin
      err_cnt++; $display("FAIL xfer_cnt: got %h, expected %h", xfer_cnt, exp_cnt);
    end
    cmp_cnt++;
    if (sb.size() != 0) begin
      err_cnt++; $display("FAIL sb_drain: %0d words pending, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_wrong_ready();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
